// File: rtl/seg_scan_receiver.sv
// seg_scan_receiver
// Samples a time-multiplexed 7-segment display bus (one-hot digit select plus
// {a,b,c,d,e,f,g} segments), waits for each digit's pattern to settle, decodes
// it back to BCD and emits one frame per full scan over a valid/ready handshake.
module seg_scan_receiver #(
    parameter int NDIG   = 4,   // number of multiplexed digits (2..8)
    parameter int STABLE = 3    // identical consecutive samples before capture (1..15)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NDIG-1:0]     dig_sel,
    input  logic [6:0]          seg_in,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [4*NDIG-1:0]   out_bcd,
    output logic [NDIG-1:0]     out_err,
    output logic                out_ovf,
    output logic                overrun
);

    // Inverse of the transmit-side decoder. Digits only ever decode to 0..9,
    // so 4'hE marks the overflow "E" pattern and 4'hF marks garbage; the
    // per-digit ovf/err flags are derived from those two codes.
    function automatic logic [3:0] seg_to_bcd(input logic [6:0] seg);
        case (seg)
            7'b1111110: seg_to_bcd = 4'd0;
            7'b0110000: seg_to_bcd = 4'd1;
            7'b1101101: seg_to_bcd = 4'd2;
            7'b1111001: seg_to_bcd = 4'd3;
            7'b0110011: seg_to_bcd = 4'd4;
            7'b1011011: seg_to_bcd = 4'd5;
            7'b1011111: seg_to_bcd = 4'd6;
            7'b1110000: seg_to_bcd = 4'd7;
            7'b1111111: seg_to_bcd = 4'd8;
            7'b1111011: seg_to_bcd = 4'd9;
            7'b1001111: seg_to_bcd = 4'hE;
            default:    seg_to_bcd = 4'hF;
        endcase
    endfunction

    // Previous sample, run length and the per-digit capture registers.
    logic [NDIG-1:0]       prev_sel;
    logic [6:0]            prev_seg;
    logic [3:0]            run_cnt;
    logic [NDIG-1:0]       mask;
    logic [NDIG-1:0][3:0]  dig_bcd;
    logic [NDIG-1:0]       dig_err;
    logic [NDIG-1:0]       dig_ovf;

    // Combinational view of this edge's capture and frame completion.
    logic                  sample_ok;
    logic                  same_sample;
    logic [4:0]            run_next;
    logic                  capture;
    logic [3:0]            nib;
    logic [NDIG-1:0]       mask_nx;
    logic [NDIG-1:0][3:0]  dig_bcd_nx;
    logic [NDIG-1:0]       dig_err_nx;
    logic [NDIG-1:0]       dig_ovf_nx;
    logic                  frame_done;

    // Run-length tracking, decode and the updated digit registers a capture
    // would produce, so a completing frame can be loaded from them directly.
    // NOTE: combinational logic uses blocking '=' and assigns every output a
    // default first, so no latch is inferred on any path.
    always_comb begin
        sample_ok   = $onehot(dig_sel);
        same_sample = sample_ok && (dig_sel == prev_sel) && (seg_in == prev_seg);
        run_next    = same_sample ? ({1'b0, run_cnt} + 5'd1) : 5'd1;
        // Only the exact crossing captures; a saturated count yields STABLE+1.
        capture     = sample_ok && (run_next == 5'(STABLE));
        nib         = seg_to_bcd(seg_in);
        mask_nx     = mask;
        dig_bcd_nx  = dig_bcd;
        dig_err_nx  = dig_err;
        dig_ovf_nx  = dig_ovf;
        if (capture) begin
            mask_nx = mask | dig_sel;
            for (int i = 0; i < NDIG; i++) begin
                if (dig_sel[i]) begin
                    dig_bcd_nx[i] = nib;
                    dig_err_nx[i] = (nib == 4'hF);
                    dig_ovf_nx[i] = (nib == 4'hE);
                end
            end
        end
        frame_done = capture && (&mask_nx);
    end

    // Sample history, digit capture, frame assembly and output handshake.
    // NOTE: every register, including the small digit store, is cleared on
    // reset so a partial frame never leaks into the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sel  <= '0;
            prev_seg  <= '0;
            run_cnt   <= '0;
            mask      <= '0;
            dig_bcd   <= '0;
            dig_err   <= '0;
            dig_ovf   <= '0;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_err   <= '0;
            out_ovf   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            prev_sel <= dig_sel;
            prev_seg <= seg_in;

            if (!sample_ok)
                run_cnt <= '0;
            else if (run_next >= 5'(STABLE))
                run_cnt <= 4'(STABLE);
            else
                run_cnt <= run_next[3:0];

            dig_bcd <= dig_bcd_nx;
            dig_err <= dig_err_nx;
            dig_ovf <= dig_ovf_nx;

            if (frame_done) begin
                mask <= '0;
                if (!out_valid || out_ready) begin
                    out_valid <= 1'b1;
                    out_bcd   <= dig_bcd_nx;
                    out_err   <= dig_err_nx;
                    out_ovf   <= |dig_ovf_nx;
                end else begin
                    overrun   <= 1'b1;
                end
            end else begin
                mask <= mask_nx;
                if (out_valid && out_ready)
                    out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_receiver.sv
// Directed testbench for seg_scan_receiver (NDIG=4, STABLE=3).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_seg_scan_receiver;

    localparam int NDIG   = 4;
    localparam int STABLE = 3;

    // Segment patterns {a,b,c,d,e,f,g}.
    localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101,
                           S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011,
                           S6 = 7'b1011111, S7 = 7'b1110000, S8 = 7'b1111111,
                           S9 = 7'b1111011, SE = 7'b1001111, SBAD = 7'b0000001;

    logic                clk = 1'b0;
    logic                rst;
    logic [NDIG-1:0]     dig_sel;
    logic [6:0]          seg_in;
    logic                out_ready;
    logic                out_valid;
    logic [4*NDIG-1:0]   out_bcd;
    logic [NDIG-1:0]     out_err;
    logic                out_ovf;
    logic                overrun;

    int n_cmp = 0;
    int n_err = 0;

    seg_scan_receiver #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .dig_sel   (dig_sel),
        .seg_in    (seg_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_bcd   (out_bcd),
        .out_err   (out_err),
        .out_ovf   (out_ovf),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one bus sample for n rising edges; returns on a falling edge.
    task automatic hold(input logic [NDIG-1:0] sel, input logic [6:0] seg, input int n);
        dig_sel = sel;
        seg_in  = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        hold('0, '0, n);
    endtask

    initial begin
        rst = 1'b1; dig_sel = '0; seg_in = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_valid",   32'(out_valid), 32'd0);
        check("reset_bcd",     32'(out_bcd),   32'd0);
        check("reset_err_ovr", 32'({out_err, out_ovf, overrun}), 32'd0);
        rst = 1'b0;

        // Basic scan: 3,7,2,9; frame appears exactly on the 3rd sample edge.
        hold(4'b0001, S3, 3);
        hold(4'b0010, S7, 3);
        hold(4'b0100, S2, 3);
        hold(4'b1000, S9, 2);
        check("lat_not_early", 32'(out_valid), 32'd0);
        hold(4'b1000, S9, 1);
        check("lat_valid",     32'(out_valid), 32'd1);
        check("basic_bcd",     32'(out_bcd),   32'h9273);
        check("basic_err",     32'(out_err),   32'd0);
        check("basic_ovf",     32'(out_ovf),   32'd0);
        idle(1);
        check("basic_pulse",   32'(out_valid), 32'd0);

        // Short run on digit 1: no frame until it is held long enough.
        hold(4'b0001, S5, 3);
        hold(4'b0010, S1, 2);
        hold(4'b0100, S8, 3);
        hold(4'b1000, S4, 3);
        check("short_noframe", 32'(out_valid), 32'd0);
        hold(4'b0010, S6, 3);
        check("short_valid",   32'(out_valid), 32'd1);
        check("short_bcd",     32'(out_bcd),   32'h4865);
        idle(1);

        // Undecodable and overflow patterns.
        hold(4'b0001, SE,   3);
        hold(4'b0010, S0,   3);
        hold(4'b0100, SBAD, 3);
        hold(4'b1000, S1,   3);
        check("errovf_valid",  32'(out_valid), 32'd1);
        check("errovf_bcd",    32'(out_bcd),   32'h1F0E);
        check("errovf_err",    32'(out_err),   32'b0100);
        check("errovf_ovf",    32'(out_ovf),   32'd1);
        idle(1);

        // Multi-hot select never captures; a glitch restarts a run.
        hold(4'b0110, S1, 5);
        hold(4'b0001, S2, 2);
        idle(1);
        hold(4'b0001, S2, 2);
        hold(4'b0010, S4, 3);
        hold(4'b0100, S5, 3);
        hold(4'b1000, S6, 3);
        check("glitch_noframe", 32'(out_valid), 32'd0);
        hold(4'b0001, S3, 3);
        check("glitch_valid",  32'(out_valid), 32'd1);
        check("glitch_bcd",    32'(out_bcd),   32'h6543);
        idle(1);
        check("glitch_drop",   32'(out_valid), 32'd0);

        // Backpressure: first frame held, second dropped, overrun sticks.
        out_ready = 1'b0;
        hold(4'b0001, S1, 3);
        hold(4'b0010, S2, 3);
        hold(4'b0100, S3, 3);
        hold(4'b1000, S4, 3);
        check("bp_first_valid", 32'(out_valid), 32'd1);
        check("bp_first_bcd",   32'(out_bcd),   32'h4321);
        check("bp_no_overrun",  32'(overrun),   32'd0);
        hold(4'b0001, S5, 3);
        hold(4'b0010, S6, 3);
        hold(4'b0100, S7, 3);
        hold(4'b1000, S8, 3);
        check("bp_held_valid",  32'(out_valid), 32'd1);
        check("bp_held_bcd",    32'(out_bcd),   32'h4321);
        check("bp_overrun",     32'(overrun),   32'd1);
        // Third frame completes on the same edge as the transfer.
        hold(4'b0001, S9, 3);
        hold(4'b0010, S0, 3);
        hold(4'b0100, S1, 3);
        hold(4'b1000, S2, 2);
        check("bp_still_held",  32'(out_bcd),   32'h4321);
        out_ready = 1'b1;
        hold(4'b1000, S2, 1);
        check("bp_xfer_valid",  32'(out_valid), 32'd1);
        check("bp_xfer_bcd",    32'(out_bcd),   32'h2109);
        check("bp_sticky",      32'(overrun),   32'd1);
        idle(1);
        check("bp_drained",     32'(out_valid), 32'd0);

        // Reset in the middle of a frame discards the partial capture.
        hold(4'b0001, S7, 3);
        hold(4'b0010, S8, 3);
        rst = 1'b1;
        idle(1);
        check("midrst_bcd",     32'(out_bcd),   32'd0);
        check("midrst_ovr",     32'({out_valid, out_err, out_ovf, overrun}), 32'd0);
        rst = 1'b0;
        hold(4'b0100, S9, 3);
        hold(4'b1000, S0, 3);
        check("midrst_noframe", 32'(out_valid), 32'd0);
        hold(4'b0001, S1, 3);
        hold(4'b0010, S2, 3);
        check("midrst_valid",   32'(out_valid), 32'd1);
        check("midrst_bcd2",    32'(out_bcd),   32'h0921);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
